alu_multicycle: RTL and testbench

Parametrised successor to the single-cycle datapath ALU. It is a registered, WIDTH-bit ALU with a valid/ready handshake on both sides. It extends the existing op set with XOR, NOR, shifts, unsigned SLT, and iterative unsigned multiply and divide. It sits between operand fetch and writeback in the multi-cycle core, and its stall comes from `in_ready`.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_iter_muldiv.sv | 87 ++++++++
 rtl/alu_multicycle.sv | 183 ++++++++++++++++++
 tb/tb_alu_multicycle.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
// Contents:
//   - op-code constants (legacy single-cycle codes kept at their old values)
//   - FSM state encoding for the top-level controller
//   - fill bit used to build the divide-by-zero quotient
package alu_pkg;

  // Op codes. AND/OR/ADD/SUB/SLT keep the values of the older single-cycle ALU
  // so existing decode tables still line up.
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  // Controller states: IDLE waits for an op, BUSY runs the iterative engine,
  // DONE presents a result until the consumer takes it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // Every quotient bit takes this value when dividing by zero (all ones).
  localparam logic DIVZ_FILL = 1'b1;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply / divide engine shared by MULU and DIVU.
// One WIDTH-bit adder and a 2*WIDTH accumulator {acc_hi, acc_lo}:
//   multiply: shift-add, multiplier in acc_lo, partial product grows in acc_hi
//   divide:   restoring, dividend shifts out of acc_lo into the remainder
//             in acc_hi while quotient bits shift in at the bottom
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start             load a/b/is_div and clear the accumulator
//   step              perform one iteration this cycle
//   is_div            1 = divide, 0 = multiply (sampled on start)
//   a, b              operands (sampled on start)
//   count             iteration counter owned by the parent
//   done              last iteration is happening this cycle
//   res_lo, res_hi    accumulator value after this cycle's iteration
module alu_iter_muldiv #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   count,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] operand_b;
  logic             div_mode;

  logic [WIDTH:0]   cand;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             fits;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  // One iteration of either algorithm. The single adder computes
  // hi + (lo[0] ? b : 0) for multiply and cand - b (as cand + ~b + 1) for
  // divide. The shifted remainder can be WIDTH+1 bits wide, so the divisor
  // fits when that extra top bit is set or the low-part subtract did not borrow.
  always_comb begin
    cand         = {acc_hi, acc_lo[WIDTH-1]};
    add_x        = div_mode ? cand[WIDTH-1:0] : acc_hi;
    add_y        = div_mode ? ~operand_b : (acc_lo[0] ? operand_b : '0);
    {carry, sum} = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, div_mode};
    fits         = cand[WIDTH] | carry;
    if (div_mode) begin
      next_hi = fits ? sum : cand[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], fits};
    end else begin
      next_hi = {carry, sum[WIDTH-1:1]};
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  assign done   = step && (count == '0);
  assign res_lo = next_lo;
  assign res_hi = next_hi;

  // Accumulator and operand registers: loaded on start, advanced on step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_b <= '0;
      div_mode  <= 1'b0;
    end else if (start) begin
      acc_hi    <= '0;
      acc_lo    <= a;
      operand_b <= b;
      div_mode  <= is_div;
    end else if (step) begin
      acc_hi    <= next_hi;
      acc_lo    <= next_lo;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on input and output.
// Single-cycle ops finish one cycle after accept; MULU/DIVU run through the
// iterative engine for WIDTH extra cycles. Results are held in DONE until the
// consumer raises out_ready.
// Ports:
//   clk, reset             clock and asynchronous active-high reset
//   in_valid / in_ready    input handshake (in_ready depends on out_ready)
//   alu_control, a, b      op code and operands, captured on accept
//   out_valid / out_ready  output handshake
//   result, result_hi      primary result; MULU high half / DIVU remainder
//   zero, overflow         result == 0; signed ADD/SUB overflow
//   illegal                the accepted op code was not recognised
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  alu_state_t       state;
  alu_state_t       state_next;
  logic [SHW-1:0]   count;
  logic             accept;
  logic             is_muldiv_op;
  logic             start;
  logic             divz;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;

  logic             eng_done;
  logic [WIDTH-1:0] eng_lo;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH-1:0] fin_lo;

  // Shared iterative engine; it steps on every BUSY cycle and flags the
  // cycle in which the counter reaches zero.
  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .step   (state == ST_BUSY),
    .is_div (alu_control == OP_DIVU),
    .a      (a),
    .b      (b),
    .count  (count),
    .done   (eng_done),
    .res_lo (eng_lo),
    .res_hi (eng_hi)
  );

  // Single-cycle datapath. MULU/DIVU fall through with zeros here; their
  // results come from the engine. Anything unrecognised yields 0 plus illegal.
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    shamt   = b[SHW-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (alu_control)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res[0] = $signed(a) < $signed(b);
      OP_SLTU: alu_res[0] = a < b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_MULU, OP_DIVU: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // Handshake decode. A DONE result being taken frees the block in the same
  // cycle, which is what allows one single-cycle op per clock.
  always_comb begin
    is_muldiv_op = (alu_control == OP_MULU) || (alu_control == OP_DIVU);
    in_ready     = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    accept       = in_valid && in_ready;
    start        = accept && is_muldiv_op;
    out_valid    = (state == ST_DONE);
    fin_lo       = divz ? {WIDTH{DIVZ_FILL}} : eng_lo;
  end

  // Next-state logic for the controller.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = is_muldiv_op ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (count == '0) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          if (accept) state_next = is_muldiv_op ? ST_BUSY : ST_DONE;
          else        state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and iteration counter. The counter loads WIDTH-1 on a
  // MULU/DIVU accept and counts down once per BUSY cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        count <= CNT_LAST;
      end else if ((state == ST_BUSY) && (count != '0)) begin
        count <= count - 1'b1;
      end
    end
  end

  // Output registers: loaded from the combinational ALU on a single-cycle
  // accept, or from the engine on its final iteration, and otherwise held.
  // divz remembers a DIVU-by-zero so the quotient is forced to all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      divz      <= 1'b0;
    end else begin
      if (start) begin
        divz <= (alu_control == OP_DIVU) && (b == '0);
      end
      if (accept && !is_muldiv_op) begin
        result    <= alu_res;
        result_hi <= '0;
        zero      <= (alu_res == '0);
        overflow  <= alu_ovf;
        illegal   <= alu_ill;
      end else if (eng_done) begin
        result    <= fin_lo;
        result_hi <= eng_hi;
        zero      <= (fin_lo == '0);
        overflow  <= 1'b0;
        illegal   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH = 32): a table of directed
// vectors with hand-computed results, then back-pressure and mid-operation
// reset sequences.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             overflow;
  logic             illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .zero        (zero),
    .overflow    (overflow),
    .illegal     (illegal)
  );

  // Compare one value and report a mismatch.
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Present one op, wait (bounded) for it to be accepted, then count cycles
  // until out_valid. lat = 1 means out_valid right after the accepting edge.
  // ready_in_busy records whether in_ready was seen high while waiting.
  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output int lat, output logic ready_in_busy);
    int wait_cnt;
    wait_cnt    = 0;
    alu_control = op;
    a           = x;
    b           = y;
    in_valid    = 1'b1;
    while (!in_ready && wait_cnt < 100) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check_output("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid      = 1'b0;
    lat           = 1;
    ready_in_busy = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_in_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int   lat;
    int   seen;
    logic rib;

    vecs[0]  = '{OP_ADD,  32'h00000007, 32'hFFFFFFF9, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1};
    vecs[2]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{OP_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{OP_OR,   32'h000000F0, 32'h00000F00, 32'h00000FF0, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{OP_XOR,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{OP_NOR,  32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{OP_SLL,  32'h00000001, 32'h0000003F, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{OP_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{OP_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1};
    vecs[12] = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1, 1};
    vecs[13] = '{OP_MULU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 1'b0, 33};
    vecs[14] = '{OP_MULU, 32'h00010000, 32'h00010000, 32'h00000000, 32'h1, 1'b1, 1'b0, 1'b0, 33};
    vecs[15] = '{OP_DIVU, 32'd100,      32'd7,        32'd14,       32'd2, 1'b0, 1'b0, 1'b0, 33};
    vecs[16] = '{OP_DIVU, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 32'h1234, 1'b0, 1'b0, 1'b0, 33};
    vecs[17] = '{OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'hF, 1'b0, 1'b0, 1'b0, 33};

    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    alu_control = 4'b0000;
    a           = '0;
    b           = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_result", result, 32'd0);
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, rib);
      check_output($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check_output($sformatf("v%0d_result", i), result, vecs[i].res);
      check_output($sformatf("v%0d_result_hi", i), result_hi, vecs[i].hi);
      check_output($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
      check_output($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      check_output($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
      if (vecs[i].lat > 1) begin
        check_output($sformatf("v%0d_busy_in_ready", i), 32'(rib), 32'd0);
      end
      @(posedge clk); #1;
      check_output($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
    end

    // Back-pressure: hold an OR result, with a pending ADD on the input.
    $display("[TB] back-pressure sequence");
    out_ready = 1'b0;
    apply_stimulus(OP_OR, 32'h0000000F, 32'h000000F0, lat, rib);
    check_output("bp_latency", 32'(lat), 32'd1);
    alu_control = OP_ADD;
    a           = 32'd5;
    b           = 32'd6;
    in_valid    = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check_output($sformatf("bp_hold%0d_result", k), result, 32'h000000FF);
      check_output($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
      check_output($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check_output("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_output("bp_new_valid", 32'(out_valid), 32'd1);
    check_output("bp_new_result", result, 32'd11);
    @(posedge clk); #1;
    check_output("bp_idle_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a MULU.
    $display("[TB] reset during MULU sequence");
    alu_control = OP_MULU;
    a           = 32'd3;
    b           = 32'd5;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_output("mr_busy_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    check_output("mr_out_valid", 32'(out_valid), 32'd0);
    check_output("mr_result", result, 32'd0);
    check_output("mr_result_hi", result_hi, 32'd0);
    check_output("mr_zero", 32'(zero), 32'd0);
    check_output("mr_overflow", 32'(overflow), 32'd0);
    check_output("mr_illegal", 32'(illegal), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_output("mr_after_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_output("mr_dropped_op", 32'(seen), 32'd0);
    apply_stimulus(OP_AND, 32'h0000F0F0, 32'h0000FF00, lat, rib);
    check_output("mr_and_latency", 32'(lat), 32'd1);
    check_output("mr_and_result", result, 32'h0000F000);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
